// File: rtl/timestamp_snap_reader.sv
// Event-driven timestamp capture: snapshots the interval timer, reads the four
// snapshot halfwords back and streams the assembled 64-bit value with its event tag.
module timestamp_snap_reader #(
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SNAP_BASE  = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            event_pulse,
    input  logic [ID_W-1:0] event_id,
    output logic [3:0]      tmr_address,
    output logic            tmr_chipselect,
    output logic            tmr_write_n,
    output logic [15:0]     tmr_writedata,
    input  logic [15:0]     tmr_readdata,
    output logic            ts_valid,
    input  logic            ts_ready,
    output logic [63:0]     ts_data,
    output logic [ID_W-1:0] ts_id,
    output logic [7:0]      drop_count,
    input  logic            drop_clear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, SNAP, RD0, RD1, RD2, RD3, CAP, OUT
    } state_t;

    state_t          state;
    logic [ID_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = (state == IDLE) && !fifo_empty;
    assign push       = event_pulse && (!fifo_full || pop);
    assign drop       = event_pulse && !push;

    assign tmr_writedata = '0;

    // NOTE: the queue storage has no reset; the pointers alone define validity,
    // and leaving the array unreset lets it map onto plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= event_id;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_clear) begin
            drop_count <= '0;
        end else if (drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Bus outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            ts_valid       <= 1'b0;
            ts_data        <= '0;
            ts_id          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        ts_id          <= fifo_mem[rd_ptr[PTR_W-1:0]];
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= 4'(SNAP_BASE);
                        state          <= SNAP;
                    end
                end
                SNAP: begin
                    tmr_write_n <= 1'b1;
                    state       <= RD0;
                end
                RD0: begin
                    tmr_address <= 4'(SNAP_BASE + 1);
                    state       <= RD1;
                end
                // Timer read data lags the address by one cycle, so each read
                // state captures the halfword addressed in the previous state.
                RD1: begin
                    ts_data[15:0] <= tmr_readdata;
                    tmr_address   <= 4'(SNAP_BASE + 2);
                    state         <= RD2;
                end
                RD2: begin
                    ts_data[31:16] <= tmr_readdata;
                    tmr_address    <= 4'(SNAP_BASE + 3);
                    state          <= RD3;
                end
                RD3: begin
                    ts_data[47:32] <= tmr_readdata;
                    tmr_chipselect <= 1'b0;
                    state          <= CAP;
                end
                CAP: begin
                    ts_data[63:48] <= tmr_readdata;
                    ts_valid       <= 1'b1;
                    state          <= OUT;
                end
                OUT: begin
                    if (ts_ready) begin
                        ts_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tmr_chipselect <= 1'b0;
                    tmr_write_n    <= 1'b1;
                    ts_valid       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timestamp_snap_reader.sv
// Scoreboard bench for timestamp_snap_reader with a behavioural timer snapshot slave.
module tb_timestamp_snap_reader;

    logic        clk;
    logic        reset_n;
    logic        event_pulse;
    logic [3:0]  event_id;
    logic [3:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        ts_valid;
    logic        ts_ready;
    logic [63:0] ts_data;
    logic [3:0]  ts_id;
    logic [7:0]  drop_count;
    logic        drop_clear;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          write_cnt = 0;
    logic [63:0] timer_value;
    logic [63:0] snap_reg;

    timestamp_snap_reader #(.ID_W(4), .FIFO_DEPTH(4), .SNAP_BASE(6)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .event_pulse    (event_pulse),
        .event_id       (event_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .ts_valid       (ts_valid),
        .ts_ready       (ts_ready),
        .ts_data        (ts_data),
        .ts_id          (ts_id),
        .drop_count     (drop_count),
        .drop_clear     (drop_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Timer slave: a write to word 6 latches the live value; reads are registered.
    initial begin
        snap_reg     = '0;
        tmr_readdata = '0;
    end
    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n && tmr_address == 4'd6)
            snap_reg <= timer_value;
        if (tmr_chipselect && tmr_write_n) begin
            case (tmr_address)
                4'd6:    tmr_readdata <= snap_reg[15:0];
                4'd7:    tmr_readdata <= snap_reg[31:16];
                4'd8:    tmr_readdata <= snap_reg[47:32];
                4'd9:    tmr_readdata <= snap_reg[63:48];
                default: tmr_readdata <= 16'hBAD0;
            endcase
        end
    end

    // Bus and output monitor, sampled midway between active edges.
    always @(negedge clk) begin
        if (reset_n) begin
            if (tmr_chipselect && !tmr_write_n) begin
                write_cnt++;
                check("wr_addr", 64'(tmr_address), 64'd6);
                check("wr_data", 64'(tmr_writedata), 64'd0);
            end
            if (ts_valid && ts_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ts", 64'(ts_id), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ts_id", 64'(ts_id), 64'(e.id));
                    check("ts_data", ts_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || ts_valid) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic push_exp(input logic [3:0] id);
        exp_t e;
        e.id   = id;
        e.data = timer_value;
        sb.push_back(e);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [2:0] exp_bus [1:7];
        logic [3:0] exp_addr [1:5];
        int n;

        reset_n     = 1'b0;
        event_pulse = 1'b0;
        event_id    = '0;
        ts_ready    = 1'b1;
        drop_clear  = 1'b0;
        timer_value = 64'h0123_4567_89AB_CDEF;

        repeat (3) tick();
        check("rst_cs", 64'(tmr_chipselect), 64'd0);
        check("rst_wn", 64'(tmr_write_n), 64'd1);
        check("rst_addr", 64'(tmr_address), 64'd0);
        check("rst_wdata", 64'(tmr_writedata), 64'd0);
        check("rst_valid", 64'(ts_valid), 64'd0);
        check("rst_data", ts_data, 64'd0);
        check("rst_id", 64'(ts_id), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single event: bus sequence and latency. {cs, write_n, valid} after edges 1..7.
        exp_bus[1] = 3'b100; exp_bus[2] = 3'b110; exp_bus[3] = 3'b110;
        exp_bus[4] = 3'b110; exp_bus[5] = 3'b110; exp_bus[6] = 3'b010;
        exp_bus[7] = 3'b011;
        exp_addr[1] = 4'd6; exp_addr[2] = 4'd6; exp_addr[3] = 4'd7;
        exp_addr[4] = 4'd8; exp_addr[5] = 4'd9;
        event_pulse = 1'b1;
        event_id    = 4'd3;
        push_exp(4'd3);
        tick();
        event_pulse = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("seq_bus_e%0d", e), 64'({tmr_chipselect, tmr_write_n, ts_valid}),
                  64'(exp_bus[e]));
            if (e <= 5)
                check($sformatf("seq_addr_e%0d", e), 64'(tmr_address), 64'(exp_addr[e]));
        end
        drain("drain_single");
        check("writes_single", 64'(write_cnt), 64'd1);

        // Five back-to-back events into a depth-4 queue with the consumer ready.
        timer_value = 64'hFEDC_BA98_7654_3210;
        for (int i = 1; i <= 5; i++) begin
            event_pulse = 1'b1;
            event_id    = 4'(i);
            push_exp(4'(i));
            tick();
        end
        event_pulse = 1'b0;
        drain("drain_burst");
        check("drop_burst", 64'(drop_count), 64'd0);

        // Consumer stalled: one in service, four queued, sixth dropped.
        timer_value = 64'h1111_2222_3333_4444;
        ts_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i < 6) begin
                event_pulse = 1'b1;
                event_id    = 4'(i);
                if (i < 5) push_exp(4'(i));
            end else begin
                event_pulse = 1'b0;
            end
            tick();
            if (i % 10 == 9) begin
                check("stall_valid", 64'(ts_valid), 64'd1);
                check("stall_id", 64'(ts_id), 64'd0);
                check("stall_data", ts_data, 64'h1111_2222_3333_4444);
            end
        end
        check("stall_drop", 64'(drop_count), 64'd1);
        ts_ready = 1'b1;
        drain("drain_stall");
        drop_clear = 1'b1;
        tick();
        drop_clear = 1'b0;
        check("drop_cleared", 64'(drop_count), 64'd0);

        // Full queue with a push in the same cycle as the IDLE pop.
        timer_value = 64'hA5A5_0F0F_5A5A_F0F0;
        ts_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            event_pulse = 1'b1;
            event_id    = 4'(i);
            push_exp(4'(i));
            tick();
        end
        event_pulse = 1'b0;
        n = 0;
        while (!ts_valid && n < 20) begin
            tick();
            n++;
        end
        check("full_wait_valid", 64'(ts_valid), 64'd1);
        ts_ready = 1'b1;
        tick();
        ts_ready    = 1'b0;
        event_pulse = 1'b1;
        event_id    = 4'd9;
        push_exp(4'd9);
        tick();
        event_pulse = 1'b0;
        check("popush_drop", 64'(drop_count), 64'd0);
        check("popush_head", 64'(ts_id), 64'd1);
        ts_ready = 1'b1;
        drain("drain_popush");

        // Drop counter saturation and clear priority.
        timer_value = 64'h0000_0000_DEAD_BEEF;
        ts_ready = 1'b0;
        for (int i = 0; i < 259; i++) begin
            event_pulse = 1'b1;
            event_id    = 4'(i);
            if (i < 5) push_exp(4'(i));
            tick();
        end
        check("drop_254", 64'(drop_count), 64'd254);
        tick();
        check("drop_255", 64'(drop_count), 64'd255);
        tick();
        check("drop_sat", 64'(drop_count), 64'd255);
        drop_clear = 1'b1;
        tick();
        check("drop_clr_prio", 64'(drop_count), 64'd0);
        drop_clear  = 1'b0;
        event_pulse = 1'b0;
        ts_ready    = 1'b1;
        drain("drain_sat");

        // Reset asserted during RD2 with a second event still queued.
        timer_value = 64'h7777_6666_5555_4444;
        event_pulse = 1'b1;
        event_id    = 4'd5;
        tick();
        event_id    = 4'd4;
        tick();
        event_pulse = 1'b0;
        repeat (3) tick();
        check("rd2_cs", 64'(tmr_chipselect), 64'd1);
        check("rd2_addr", 64'(tmr_address), 64'd8);
        reset_n = 1'b0;
        #1;
        check("abort_cs", 64'(tmr_chipselect), 64'd0);
        check("abort_wn", 64'(tmr_write_n), 64'd1);
        check("abort_valid", 64'(ts_valid), 64'd0);
        check("abort_data", ts_data, 64'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ts_valid) check("abort_no_ts", 64'(ts_valid), 64'd0);
        end
        timer_value = 64'h0F1E_2D3C_4B5A_6978;
        event_pulse = 1'b1;
        event_id    = 4'd6;
        push_exp(4'd6);
        tick();
        event_pulse = 1'b0;
        drain("drain_reset");

        check("write_total", 64'(write_cnt), 64'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
